// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch stage: FSM states, buffered entry
// layout and the word-alignment helper used for memory addresses.
package fetch_pkg;

  localparam int FETCH_ADDR_W    = 32;
  localparam int FETCH_DATA_W    = 32;
  localparam int FETCH_BUF_DEPTH = 2;

  typedef enum logic [1:0] {
    ISSUE = 2'd0,
    WAIT  = 2'd1,
    DRAIN = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [FETCH_ADDR_W-1:0] pc;
    logic [FETCH_DATA_W-1:0] instr;
  } fetch_entry_t;

  function automatic logic [FETCH_ADDR_W-1:0] word_align(input logic [FETCH_ADDR_W-1:0] addr);
    return {addr[FETCH_ADDR_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry FIFO of fetched {pc, instr} pairs; clear wins over push and pop.
module fetch_buffer
  import fetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  fetch_entry_t push_entry,
  input  logic         pop,
  input  logic         clear,
  output logic [1:0]   count,
  output logic         head_valid,
  output fetch_entry_t head_entry
);

  fetch_entry_t r_mem [0:FETCH_BUF_DEPTH-1];
  logic         r_rd_ptr;
  logic         r_wr_ptr;
  logic [1:0]   r_count;
  logic         w_do_push;
  logic         w_do_pop;

  assign w_do_pop   = pop & (r_count != 2'd0);
  // A push while full is only legal when the head leaves in the same cycle.
  assign w_do_push  = push & ((r_count < 2'(FETCH_BUF_DEPTH)) | w_do_pop);
  assign count      = r_count;
  assign head_valid = (r_count != 2'd0);
  assign head_entry = r_mem[r_rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FETCH_BUF_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else if (clear) begin
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= push_entry;
        r_wr_ptr        <= ~r_wr_ptr;
      end else begin
        r_wr_ptr <= r_wr_ptr;
      end
      if (w_do_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end else begin
        r_rd_ptr <= r_rd_ptr;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: one outstanding imem read, 2-entry instruction buffer toward
// decode, PC hold for the next-PC mux and single-cycle flush on redirect.
module instruction_fetch_unit
  import fetch_pkg::*;
#(
  parameter int ADDR_W = FETCH_ADDR_W,
  parameter int DATA_W = FETCH_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] pcAddr,
  output logic              pcHold,
  input  logic              flush,
  output logic              imemReq,
  output logic [ADDR_W-1:0] imemAddr,
  input  logic              imemGnt,
  input  logic              imemRvalid,
  input  logic [DATA_W-1:0] imemRdata,
  output logic              instrValid,
  output logic [DATA_W-1:0] instrData,
  output logic [ADDR_W-1:0] instrPc,
  input  logic              instrReady
);

  fetch_state_e      r_state;
  logic [ADDR_W-1:0] r_pend_pc;

  logic [1:0]        w_count;
  logic              w_req;
  logic              w_grant;
  logic              w_push;
  logic              w_pop;
  logic              w_head_valid;
  fetch_entry_t      w_push_entry;
  fetch_entry_t      w_head;

  // Issuing only below full reserves a buffer slot for the response.
  assign w_req    = (r_state == ISSUE) & (w_count < 2'(FETCH_BUF_DEPTH)) & ~flush & reset;
  assign w_grant  = w_req & imemGnt;
  assign imemReq  = w_req;
  assign imemAddr = word_align(pcAddr);
  assign pcHold   = ~reset | (~flush & ~w_grant);

  assign w_push       = (r_state == WAIT) & imemRvalid & ~flush;
  assign w_pop        = w_head_valid & instrReady;
  assign w_push_entry = '{pc: r_pend_pc, instr: imemRdata};

  assign instrValid = w_head_valid;
  assign instrData  = w_head.instr;
  assign instrPc    = w_head.pc;

  // Request-tracking FSM; DRAIN swallows the response of a flushed request.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= ISSUE;
      r_pend_pc <= '0;
    end else begin
      case (r_state)
        ISSUE: begin
          if (w_grant) begin
            r_state   <= WAIT;
            r_pend_pc <= word_align(pcAddr);
          end else begin
            r_state <= ISSUE;
          end
        end
        WAIT: begin
          if (imemRvalid) begin
            r_state <= ISSUE;
          end else if (flush) begin
            r_state <= DRAIN;
          end else begin
            r_state <= WAIT;
          end
        end
        DRAIN: begin
          if (imemRvalid) begin
            r_state <= ISSUE;
          end else begin
            r_state <= DRAIN;
          end
        end
        default: r_state <= ISSUE;
      endcase
    end
  end

  fetch_buffer u_buf (
    .clk        (clk),
    .rst_n      (reset),
    .push       (w_push),
    .push_entry (w_push_entry),
    .pop        (w_pop),
    .clear      (flush),
    .count      (w_count),
    .head_valid (w_head_valid),
    .head_entry (w_head)
  );

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Randomized scoreboard bench for instruction_fetch_unit with a queue-level
// reference model of outstanding requests and decode-visible instructions.
module tb_instruction_fetch_unit;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  logic        clk;
  logic        reset;
  logic [31:0] pcAddr;
  logic        pcHold;
  logic        flush;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic        imemGnt;
  logic        imemRvalid;
  logic [31:0] imemRdata;
  logic        instrValid;
  logic [31:0] instrData;
  logic [31:0] instrPc;
  logic        instrReady;

  int n_vec = 0;
  int n_err = 0;

  ent_t        exp_q[$];
  bit          outstanding = 1'b0;
  bit          kept        = 1'b0;
  logic [31:0] pend_pc     = 32'h0;
  logic [31:0] pc_m        = 32'h0040_0000;
  int          dly         = 0;

  instruction_fetch_unit dut (
    .clk        (clk),
    .reset      (reset),
    .pcAddr     (pcAddr),
    .pcHold     (pcHold),
    .flush      (flush),
    .imemReq    (imemReq),
    .imemAddr   (imemAddr),
    .imemGnt    (imemGnt),
    .imemRvalid (imemRvalid),
    .imemRdata  (imemRdata),
    .instrValid (instrValid),
    .instrData  (instrData),
    .instrPc    (instrPc),
    .instrReady (instrReady)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus: drive at negedge, check combinational outputs,
  // then advance the reference model to what the coming rising edge does.
  task automatic cycle(input logic rst_i, input logic fl, input logic [31:0] tgt,
                       input logic gnt, input logic rv, input logic [31:0] rd,
                       input logic rdy);
    bit exp_req;
    bit exp_hold;
    @(negedge clk);
    reset = rst_i; flush = fl; imemGnt = gnt; imemRvalid = rv;
    imemRdata = rd; instrReady = rdy; pcAddr = pc_m;
    #1;
    exp_req  = rst_i && !outstanding && (exp_q.size() < 2) && !fl;
    exp_hold = !rst_i || (!fl && !(exp_req && gnt));
    chk("imemReq", {31'd0, imemReq}, {31'd0, exp_req});
    chk("pcHold", {31'd0, pcHold}, {31'd0, exp_hold});
    chk("imemAddr", imemAddr, {pc_m[31:2], 2'b00});
    chk("instrValid", {31'd0, instrValid}, {31'd0, (rst_i && exp_q.size() > 0)});
    if (!rst_i) begin
      chk("instrData_rst", instrData, 32'h0);
      chk("instrPc_rst", instrPc, 32'h0);
      exp_q.delete();
      outstanding = 1'b0;
      kept        = 1'b0;
    end else begin
      if (fl) exp_q.delete();
      if (outstanding && rv) begin
        if (kept && !fl) exp_q.push_back('{pc: pend_pc, instr: rd});
        outstanding = 1'b0;
      end else if (outstanding && fl) begin
        kept = 1'b0;
      end
      if (exp_req && gnt) begin
        outstanding = 1'b1;
        kept        = 1'b1;
        pend_pc     = {pc_m[31:2], 2'b00};
        dly         = $urandom_range(0, 3);
      end
      if (fl) pc_m = tgt;
      else if (!exp_hold) pc_m = pc_m + 32'd4;
    end
  endtask

  // Monitor: every visible head must match the oldest expected entry.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (reset === 1'b1 && flush === 1'b0 && instrValid === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL head_unexpected: got pc %h instr %h expected no entry", instrPc, instrData);
        end else begin
          chk("instrPc", instrPc, exp_q[0].pc);
          chk("instrData", instrData, exp_q[0].instr);
          if (instrReady) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    logic        r_i, fl, gnt, rv, rdy;
    logic [31:0] tgt;
    reset = 1'b0; flush = 1'b0; imemGnt = 1'b0; imemRvalid = 1'b0;
    imemRdata = 32'h0; instrReady = 1'b0; pcAddr = 32'h0;

    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    pc_m = 32'h0040_0000;

    // first fetch: grant, response next cycle, visible the cycle after
    cycle(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1);
    cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'h2008_0005, 1'b1);
    cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);

    // decode stalled: buffer fills to two, then drains in order
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, 32'h0, 1'b1, outstanding, $urandom, 1'b0);
    for (int i = 0; i < 8; i++)  cycle(1'b1, 1'b0, 32'h0, 1'b1, outstanding, $urandom, 1'b1);
    while (outstanding) cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, $urandom, 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);

    // flush in WAIT, late response is drained, refetch from target
    cycle(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1);
    cycle(1'b1, 1'b1, 32'h0040_0100, 1'b0, 1'b0, 32'h0, 1'b1);
    cycle(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1);
    cycle(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1);
    cycle(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'hDEAD_BEEF, 1'b1);
    cycle(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1);
    cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'h1234_5678, 1'b1);
    cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);

    // flush coincident with the response: no push, back to issuing
    cycle(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1);
    cycle(1'b1, 1'b1, 32'h0040_0200, 1'b0, 1'b1, 32'hBADC_0DE5, 1'b1);

    // grant withheld: request and address hold steady
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);

    // reset mid-transaction, stray response afterwards is ignored
    cycle(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1);
    cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
    cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
    cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'hCAFE_F00D, 1'b1);
    cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);

    for (int i = 0; i < 3000; i++) begin
      r_i = ($urandom_range(0, 199) != 0);
      fl  = ($urandom_range(0, 19) == 0);
      tgt = $urandom;
      gnt = ($urandom_range(0, 9) < 7);
      rdy = ($urandom_range(0, 9) < 6);
      if (outstanding) begin
        rv = (dly == 0);
        if (dly != 0) dly--;
      end else begin
        rv = ($urandom_range(0, 29) == 0);
      end
      cycle(r_i, fl, tgt, gnt, rv, $urandom, rdy);
    end

    @(negedge clk);
    #5;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Fetch stage consuming the current PC from the program counter register and turning it into instruction-memory read transactions. Holds one outstanding request, buffers returned instructions (with their PC) in a 2-entry queue for decode, and drives the hold signal the next-PC mux uses to recirculate the PC while fetch is stalled. Supports a single-cycle flush for branch/jump redirects.

## Interface
- ADDR_W, 32, address/PC width
- DATA_W, 32, instruction width
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low; clears all state
- pcAddr  in  ADDR_W  current PC from program counter
- pcHold  out  1  1 = next-PC mux must feed pcAddr back unchanged
- flush  in  1  redirect: discard in-flight and buffered instructions
- imemReq  out  1  read request valid
- imemAddr  out  ADDR_W  word-aligned read address, {pcAddr[ADDR_W-1:2],2'b00}
- imemGnt  in  1  memory accepts request this cycle (qualified by imemReq)
- imemRvalid  in  1  read data valid; in-order, exactly one per grant
- imemRdata  in  DATA_W  read data
- instrValid  out  1  buffer head valid
- instrData  out  DATA_W  head instruction
- instrPc  out  ADDR_W  PC of head instruction
- instrReady  in  1  decode consumes head when instrValid & instrReady

## Operation
- States: ISSUE (no outstanding), WAIT (one outstanding, result kept), DRAIN (one outstanding, result discarded).
- imemReq = (state==ISSUE) & (count + 0 < 2) & !flush & reset; count = buffer occupancy after this cycle's pop is not credited (uses registered count).
- pcHold = !(imemReq & imemGnt); PC advances only on the granted cycle. During reset pcHold=1.
- ISSUE + grant -> WAIT; latch pcAddr as pending PC.
- WAIT + imemRvalid -> push {pending PC, imemRdata}; -> ISSUE.
- flush: buffer cleared, imemReq forced 0, pcHold=0 (mux loads redirect target). From WAIT without same-cycle rvalid -> DRAIN; otherwise -> ISSUE.
- DRAIN + imemRvalid -> data dropped, -> ISSUE. flush in DRAIN stays DRAIN.
- imemRvalid in ISSUE is a protocol error: ignored, no push.
- Buffer never overflows: issue requires count<2 so the response slot is reserved.
- Pop and push same cycle allowed; count unchanged.
- pcAddr[1:0] ignored.

## Timing
- Reset values: state ISSUE, count 0, instrValid 0, instrData 0, instrPc 0, pending PC 0.
- Grant at cycle T, earliest rvalid T+1, instrValid earliest T+2 (registered buffer, no bypass).
- Back-to-back: with single-cycle memory and instrReady=1, one grant every 2 cycles.
- instrData/instrPc stable while instrValid=1 & instrReady=0.
- Flush at T: instrValid=0 at T+1; first request from target at T+1 if state ISSUE, else after drain.
- Reset mid-transaction: any later rvalid for the dropped request arrives in ISSUE and is ignored.

## Structure
- Package fetch_pkg: state enum (ISSUE, WAIT, DRAIN), fetch_entry_t struct {pc, instr}, FETCH_BUF_DEPTH=2.
- Sub-module fetch_buffer: 2-entry FIFO of fetch_entry_t with push, pop, clear, count, head outputs; async active-low reset.

## Test plan
- Reset release, pcAddr=0x00400000, gnt=1, rvalid next cycle with 0x20080005 -> instrValid two cycles after grant, instrPc=0x00400000, instrData=0x20080005; pcHold=0 exactly on grant cycle.
- instrReady=0, three fetches attempted -> two entries buffered, imemReq low with count 2, pcHold=1; raise instrReady -> in-order drain, fetch resumes.
- Flush in WAIT, rvalid 3 cycles later with 0xDEADBEEF -> discarded, never on instrData; next grant uses target PC 0x00400100.
- Flush same cycle as rvalid -> no push, state ISSUE next cycle, no DRAIN.
- imemGnt held 0 for 5 cycles -> imemReq stays 1, pcHold=1, imemAddr constant.
- reset asserted while WAIT -> outputs zero immediately; stray rvalid after release ignored, instrValid stays 0.
